// File: rtl/lsd_segment_filter.sv
// Line-segment post-filter: 3-stage pipeline that drops short segments and caps passes per frame.
// No backpressure; LSD_FILTER_BBOX_EN adds an active-image endpoint bounds check.
module lsd_segment_filter #(
  parameter int FRAME_WIDTH  = 800,
  parameter int FRAME_HEIGHT = 525,
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480,
  parameter int MIN_LEN      = 16,
  parameter int MAX_SEGS     = 1024,
  localparam int WH = $clog2(FRAME_WIDTH),
  localparam int WV = $clog2(FRAME_HEIGHT),
  localparam int WC = $clog2(MAX_SEGS + 1)
) (
  input  logic          pixel_clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          in_flag,
  input  logic [WV-1:0] in_vcnt,
  input  logic [WH-1:0] in_hcnt,
  input  logic [WV-1:0] in_start_v,
  input  logic [WV-1:0] in_end_v,
  input  logic [WH-1:0] in_start_h,
  input  logic [WH-1:0] in_end_h,
  output logic          out_valid,
  output logic          out_flag,
  output logic [WV-1:0] out_vcnt,
  output logic [WH-1:0] out_hcnt,
  output logic [WV-1:0] out_start_v,
  output logic [WV-1:0] out_end_v,
  output logic [WH-1:0] out_start_h,
  output logic [WH-1:0] out_end_h,
  output logic [WC-1:0] out_pass_count,
  output logic [15:0]   out_drop_count
);

  localparam int WM = (WH > WV) ? WH : WV;
  localparam int WS = 2 * WM + 1;
  localparam logic [WS-1:0] MIN_SQ = WS'(MIN_LEN * MIN_LEN);
  localparam logic [WC-1:0] CAP    = WC'(MAX_SEGS);

  logic [WH-1:0] w_dx;
  logic [WV-1:0] w_dy;
  logic          w_inb;

  assign w_dx = (in_end_h >= in_start_h) ? (in_end_h - in_start_h) : (in_start_h - in_end_h);
  assign w_dy = (in_end_v >= in_start_v) ? (in_end_v - in_start_v) : (in_start_v - in_end_v);

`ifdef LSD_FILTER_BBOX_EN
  localparam logic [WH:0] IMG_W = (WH+1)'(IMAGE_WIDTH);
  localparam logic [WV:0] IMG_H = (WV+1)'(IMAGE_HEIGHT);
  assign w_inb = ({1'b0, in_start_h} < IMG_W) && ({1'b0, in_end_h} < IMG_W) &&
                 ({1'b0, in_start_v} < IMG_H) && ({1'b0, in_end_v} < IMG_H);
`else
  assign w_inb = 1'b1;
`endif

  logic          r1_valid, r1_f, r1_inb;
  logic [WV-1:0] r1_vcnt, r1_sv, r1_ev;
  logic [WH-1:0] r1_hcnt, r1_sh, r1_eh;
  logic [WH-1:0] r1_dx;
  logic [WV-1:0] r1_dy;

  logic          r2_valid, r2_f, r2_inb;
  logic [WV-1:0] r2_vcnt, r2_sv, r2_ev;
  logic [WH-1:0] r2_hcnt, r2_sh, r2_eh;
  logic [WS-1:0] r2_sq;

  logic [WC-1:0] r_run_pass;
  logic [15:0]   r_run_drop;

  logic [WS-1:0] w_sq;
  logic          w_bound, w_under_cap, w_pass, w_drop;
  logic [WC-1:0] w_pass_base;
  logic [15:0]   w_drop_base;

  assign w_sq = WS'(r1_dx) * WS'(r1_dx) + WS'(r1_dy) * WS'(r1_dy);

  // A boundary slot opens the new frame, so it is judged against an empty cap.
  assign w_bound     = r2_valid && (r2_vcnt == '0) && (r2_hcnt == '0);
  assign w_under_cap = w_bound || (r_run_pass < CAP);
  assign w_pass      = r2_f && r2_inb && (r2_sq >= MIN_SQ) && w_under_cap;
  assign w_drop      = r2_f && !w_pass;
  assign w_pass_base = w_bound ? '0 : r_run_pass;
  assign w_drop_base = w_bound ? '0 : r_run_drop;

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      r1_valid <= 1'b0; r1_f <= 1'b0; r1_inb <= 1'b0;
      r1_vcnt <= '0; r1_sv <= '0; r1_ev <= '0;
      r1_hcnt <= '0; r1_sh <= '0; r1_eh <= '0;
      r1_dx <= '0; r1_dy <= '0;
      r2_valid <= 1'b0; r2_f <= 1'b0; r2_inb <= 1'b0;
      r2_vcnt <= '0; r2_sv <= '0; r2_ev <= '0;
      r2_hcnt <= '0; r2_sh <= '0; r2_eh <= '0;
      r2_sq <= '0;
      out_valid <= 1'b0; out_flag <= 1'b0;
      out_vcnt <= '0; out_hcnt <= '0;
      out_start_v <= '0; out_end_v <= '0; out_start_h <= '0; out_end_h <= '0;
      out_pass_count <= '0; out_drop_count <= '0;
      r_run_pass <= '0; r_run_drop <= '0;
    end else begin
      r1_valid <= in_valid;
      r1_f     <= in_valid & in_flag;
      r1_inb   <= w_inb;
      r1_vcnt  <= in_vcnt;    r1_hcnt <= in_hcnt;
      r1_sv    <= in_start_v; r1_ev   <= in_end_v;
      r1_sh    <= in_start_h; r1_eh   <= in_end_h;
      r1_dx    <= w_dx;       r1_dy   <= w_dy;

      r2_valid <= r1_valid;   r2_f    <= r1_f;    r2_inb <= r1_inb;
      r2_vcnt  <= r1_vcnt;    r2_hcnt <= r1_hcnt;
      r2_sv    <= r1_sv;      r2_ev   <= r1_ev;
      r2_sh    <= r1_sh;      r2_eh   <= r1_eh;
      r2_sq    <= w_sq;

      out_valid   <= r2_valid;
      out_flag    <= w_pass;
      out_vcnt    <= r2_vcnt;  out_hcnt  <= r2_hcnt;
      out_start_v <= r2_sv;    out_end_v <= r2_ev;
      out_start_h <= r2_sh;    out_end_h <= r2_eh;

      if (w_bound) begin
        out_pass_count <= r_run_pass;
        out_drop_count <= r_run_drop;
      end
      r_run_pass <= w_pass_base + WC'(w_pass);
      r_run_drop <= (w_drop && (w_drop_base != 16'hFFFF)) ? (w_drop_base + 16'd1) : w_drop_base;
    end
  end

endmodule
